course_generator: RTL and testbench

Generates the left/right box course for one race and writes it into the box shifter. The shifter consumes the course one box per correct key press; this block is the writer that fills it. On a start request it builds a STEPS-box pattern from a free-running LFSR and caps runs of same-side boxes at MAX_RUN. It then presents the pattern as a parallel load word with a one-cycle active-low load strobe. It sits between the game-control logic (start = new game) and the shifter's loadval/load_n inputs.

---
 rtl/course_generator_if.sv | 37 +++
 rtl/course_generator.sv | 172 +++++++++++++++++
 tb/tb_course_generator.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/course_generator_if.sv
`default_nettype none
// ============================================================================
// Module      : course_generator_if
// Description : Bundle between the course generator, the game-control logic
//               and the box shifter. The generator takes the master side.
//               The shifter/controller takes the slave side.
//   start        controller -> generator : request a new course
//   course       generator  -> shifter   : parallel load word, STEPS+1 bits
//   load_n       generator  -> shifter   : active-low one-cycle load strobe
//   busy         generator  -> controller: generation in progress
//   done         generator  -> controller: one-cycle pulse with load_n low
//   right_count  generator  -> controller: number of right boxes in course
// Revision    : 1.0 - initial release
// ============================================================================
interface course_generator_if #(
    parameter int STEPS = 32
);
    localparam int c_cnt_w = $clog2(STEPS + 1);

    logic                start;
    logic [STEPS:0]      course;
    logic                load_n;
    logic                busy;
    logic                done;
    logic [c_cnt_w-1:0]  right_count;

    modport master (
        input  start,
        output course, load_n, busy, done, right_count
    );

    modport slave (
        output start,
        input  course, load_n, busy, done, right_count
    );
endinterface
`default_nettype wire

// File: rtl/course_generator.sv
`default_nettype none
// ============================================================================
// Module      : course_generator
// Description : Builds a STEPS-box left/right course from a free-running
//               16-bit Galois LFSR. Runs of same-side boxes are capped at
//               MAX_RUN. The course is handed to the box shifter as a
//               parallel word with a one-cycle active-low load strobe.
// Ports       : clk     - system clock
//               resetn  - asynchronous active-low reset
//               bus     - course_generator_if.master:
//                         start (in), course, load_n, busy, done,
//                         right_count (out)
// Revision    : 1.0 - initial release
// ============================================================================
module course_generator #(
    parameter int          STEPS   = 32,
    parameter int          MAX_RUN = 3,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  wire logic          clk,
    input  wire logic          resetn,
    course_generator_if.master bus
);

    localparam int                c_kw        = $clog2(STEPS);
    localparam int                c_cw        = $clog2(STEPS + 1);
    localparam int                c_rw        = $clog2(MAX_RUN + 1);
    localparam logic [15:0]       c_taps      = 16'hB400;
    // An all-zero Galois LFSR never leaves zero, so a zero seed is replaced.
    localparam logic [15:0]       c_lfsr_init = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [c_kw-1:0]   c_k_last    = c_kw'(STEPS - 1);
    localparam logic [c_rw-1:0]   c_run_max   = c_rw'(MAX_RUN);
    localparam logic [c_rw-1:0]   c_run_one   = c_rw'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_LOAD = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [15:0]        r_lfsr;
    logic [c_kw-1:0]    r_k;
    logic [STEPS-1:0]   r_shadow;
    logic [c_rw-1:0]    r_run;
    logic               r_prev;
    logic [c_cw-1:0]    r_tally;
    logic [STEPS:0]     r_course;
    logic [c_cw-1:0]    r_right;
    logic               r_load_n;
    logic               r_done;
    logic               r_busy;

    logic               w_rbit;
    logic               w_first;
    logic               w_bit;
    logic [c_rw-1:0]    w_run_next;

    // ------------------------------------------------------------------
    // Free-running LFSR: shifts every cycle regardless of state, so the
    // course depends on when start arrives as well as on the seed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_lfsr <= c_lfsr_init;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_taps : 16'h0000);
        end
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_next = S_FILL;
            S_FILL:  if (r_k == c_k_last) w_state_next = S_LOAD;
            S_LOAD:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Box selection: take the random bit unless it would extend a run
    // that has already reached MAX_RUN, in which case switch sides.
    // ------------------------------------------------------------------
    always_comb begin
        w_rbit  = r_lfsr[0];
        w_first = (r_k == '0);
        w_bit   = w_rbit;
        if (!w_first && (r_run == c_run_max) && (w_rbit == r_prev)) begin
            w_bit = ~r_prev;
        end

        w_run_next = c_run_one;
        if (!w_first && (w_bit == r_prev)) begin
            // Saturate: the run can only sit at MAX_RUN, never exceed it.
            w_run_next = (r_run == c_run_max) ? r_run : (r_run + c_run_one);
        end
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs. course/right_count only move in
    // LOAD so the shifter keeps a stable previous course during FILL.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_k      <= '0;
            r_shadow <= '0;
            r_run    <= '0;
            r_prev   <= 1'b0;
            r_tally  <= '0;
            r_course <= '0;
            r_right  <= '0;
            r_load_n <= 1'b1;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_load_n <= 1'b1;
            r_done   <= 1'b0;
            r_busy   <= (w_state_next != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    r_k      <= '0;
                    r_shadow <= '0;
                    r_run    <= '0;
                    r_prev   <= 1'b0;
                    r_tally  <= '0;
                end
                S_FILL: begin
                    r_shadow[r_k] <= w_bit;
                    r_prev        <= w_bit;
                    r_run         <= w_run_next;
                    r_tally       <= r_tally + c_cw'(w_bit);
                    r_k           <= r_k + c_kw'(1);
                end
                S_LOAD: begin
                    // Top bit is the finish marker and is always left.
                    r_course <= {1'b0, r_shadow};
                    r_right  <= r_tally;
                    r_load_n <= 1'b0;
                    r_done   <= 1'b1;
                end
                default: begin
                    r_k <= '0;
                end
            endcase
        end
    end

    assign bus.course      = r_course;
    assign bus.right_count = r_right;
    assign bus.load_n      = r_load_n;
    assign bus.done        = r_done;
    assign bus.busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_course_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_course_generator
// Description : Self-checking bench for course_generator. Three instances
//               share clock, reset and start:
//                 cfg0 MAX_RUN=3 SEED=ACE1, cfg1 MAX_RUN=1 SEED=ACE1,
//                 cfg2 MAX_RUN=3 SEED=0.
//               A reference model predicts each accepted course and queues
//               it. A monitor compares the outputs every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_course_generator;

    localparam int STEPS = 32;
    localparam int NCFG  = 3;

    typedef struct {
        int             at_cyc;
        logic [STEPS:0] course;
        int             rc;
    } exp_t;

    logic clk     = 1'b0;
    logic resetn  = 1'b0;
    logic start   = 1'b0;
    logic end_chk = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Course from the LFSR value present in the first FILL cycle: raw
    // random bits first, then each bit is flipped whenever the trailing
    // run of the course built so far already has mr equal boxes.
    function automatic logic [STEPS:0] ref_course(input logic [15:0] l0, input int mr);
        logic [STEPS-1:0] raw;
        logic [STEPS:0]   c;
        logic [15:0]      l;
        int               len;
        l = l0;
        for (int k = 0; k < STEPS; k++) begin
            raw[k] = l[0];
            l      = lfsr_next(l);
        end
        c = '0;
        for (int k = 0; k < STEPS; k++) begin
            c[k] = raw[k];
            if (k > 0) begin
                len = 0;
                for (int j = k - 1; j >= 0; j--) begin
                    if (c[j] != c[k-1]) break;
                    len++;
                end
                if (len >= mr && raw[k] == c[k-1]) c[k] = ~c[k-1];
            end
        end
        return c;
    endfunction

    function automatic int max_run(input logic [STEPS-1:0] v);
        int best = 1;
        int cur  = 1;
        for (int k = 1; k < STEPS; k++) begin
            if (v[k] == v[k-1]) cur++;
            else cur = 1;
            if (cur > best) best = cur;
        end
        return best;
    endfunction

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int          MR = (g == 1) ? 1 : 3;
        localparam logic [15:0] SD = (g == 2) ? 16'h0000 : 16'hACE1;

        course_generator_if #(.STEPS(STEPS)) u_if ();

        course_generator #(
            .STEPS   (STEPS),
            .MAX_RUN (MR),
            .SEED    (SD)
        ) u_dut (
            .clk    (clk),
            .resetn (resetn),
            .bus    (u_if.master)
        );

        assign u_if.start = start;

        exp_t           exp_q[$];
        logic [15:0]    m_lfsr   = (SD == 16'h0000) ? 16'h0001 : SD;
        int             cyc      = 0;
        int             free_at  = 0;
        int             busy_lo  = -1;
        int             busy_hi  = -2;
        logic [STEPS:0] m_course = '0;
        int             m_rc     = 0;

        // Model: a start seen while free launches a course whose load
        // pulse follows STEPS+1 edges later; the block is free again one
        // edge after that pulse.
        always @(posedge clk or negedge resetn) begin
            exp_t e;
            if (!resetn) begin
                m_lfsr  = (SD == 16'h0000) ? 16'h0001 : SD;
                cyc     = 0;
                free_at = 0;
                busy_lo = -1;
                busy_hi = -2;
                exp_q.delete();
            end else begin
                cyc++;
                m_lfsr = lfsr_next(m_lfsr);
                if (start && cyc >= free_at) begin
                    e.at_cyc = cyc + STEPS + 1;
                    e.course = ref_course(m_lfsr, MR);
                    e.rc     = $countones(e.course);
                    exp_q.push_back(e);
                    free_at  = cyc + STEPS + 2;
                    busy_lo  = cyc;
                    busy_hi  = cyc + STEPS;
                end
            end
        end

        always @(negedge clk) begin
            bit   lo;
            exp_t e;
            if (!resetn) begin
                m_course = '0;
                m_rc     = 0;
            end
            lo = (exp_q.size() > 0) && (exp_q[0].at_cyc == cyc);
            chk(u_if.load_n == !lo, $sformatf("cfg%0d load_n cyc%0d", g, cyc), u_if.load_n, !lo);
            chk(u_if.done == lo, $sformatf("cfg%0d done cyc%0d", g, cyc), u_if.done, lo);
            if (lo) begin
                e        = exp_q.pop_front();
                m_course = e.course;
                m_rc     = e.rc;
                chk(u_if.course[STEPS] == 1'b0, $sformatf("cfg%0d finish_marker", g),
                    u_if.course[STEPS], 0);
                chk(max_run(u_if.course[STEPS-1:0]) <= MR, $sformatf("cfg%0d run_rule", g),
                    max_run(u_if.course[STEPS-1:0]), MR);
                chk($countones(u_if.course[STEPS-1:0]) == int'(u_if.right_count),
                    $sformatf("cfg%0d popcount", g), u_if.right_count,
                    $countones(u_if.course[STEPS-1:0]));
            end
            chk(u_if.course == m_course, $sformatf("cfg%0d course cyc%0d", g, cyc),
                u_if.course, m_course);
            chk(int'(u_if.right_count) == m_rc, $sformatf("cfg%0d right_count cyc%0d", g, cyc),
                u_if.right_count, m_rc);
            chk(u_if.busy == (cyc >= busy_lo && cyc <= busy_hi),
                $sformatf("cfg%0d busy cyc%0d", g, cyc), u_if.busy,
                (cyc >= busy_lo && cyc <= busy_hi));
        end

        // Asynchronous reset must clear the outputs without a clock edge.
        always @(negedge resetn) begin
            #1;
            chk(u_if.course == '0, $sformatf("cfg%0d rst course", g), u_if.course, 0);
            chk(u_if.right_count == '0, $sformatf("cfg%0d rst right_count", g), u_if.right_count, 0);
            chk(u_if.load_n == 1'b1, $sformatf("cfg%0d rst load_n", g), u_if.load_n, 1);
            chk(u_if.busy == 1'b0, $sformatf("cfg%0d rst busy", g), u_if.busy, 0);
            chk(u_if.done == 1'b0, $sformatf("cfg%0d rst done", g), u_if.done, 0);
        end

        always @(posedge end_chk) begin
            chk(exp_q.size() == 0, $sformatf("cfg%0d pending_loads", g), exp_q.size(), 0);
        end

        if (g == 1) begin : g_alt
            always @(negedge clk) begin
                if (resetn && u_if.load_n == 1'b0) begin
                    chk(u_if.course == {1'b0, 32'h5555_5555} || u_if.course == {1'b0, 32'hAAAA_AAAA},
                        "cfg1 alternation", u_if.course, {1'b0, 32'h5555_5555});
                    chk(u_if.right_count == 6'd16, "cfg1 alt right_count", u_if.right_count, 16);
                end
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic mid_cycle_reset();
        #3 resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        // power-on reset, then a mid-cycle reset with idle time after it
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (10) @(negedge clk);
        mid_cycle_reset();
        repeat (10) @(negedge clk);

        // single generation
        pulse_start();
        repeat (40) @(negedge clk);

        // starts during FILL are ignored
        pulse_start();
        repeat (5) @(negedge clk);
        pulse_start();
        repeat (14) @(negedge clk);
        pulse_start();
        repeat (30) @(negedge clk);

        // abort in the middle of FILL, then a normal course
        pulse_start();
        repeat (10) @(negedge clk);
        mid_cycle_reset();
        repeat (5) @(negedge clk);
        pulse_start();
        repeat (40) @(negedge clk);

        // start held high: back-to-back courses
        start = 1'b1;
        repeat (70) @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);

        // randomized start patterns with occasional resets
        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                mid_cycle_reset();
            end else begin
                start = 1'($urandom_range(0, 1));
                repeat ($urandom_range(1, 40)) @(negedge clk);
            end
        end
        start = 1'b0;
        repeat (40) @(negedge clk);

        end_chk = 1'b1;
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
